led_scan_ctrl: RTL and testbench
================================

LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 Parameter COLS, 64, pixels shifted per scan row (power of two, 4..256).
REQ-002 Parameter ROW_W, 5, scan-row address width (2^ROW_W scan rows).
REQ-003 Parameter PLANES, 4, BCM bit planes per pixel (1..8).
REQ-004 ACLK  in  1  the block's only clock, rising edge.
REQ-005 ARESETN  in  1  reset, synchronous to ACLK, active-low.
REQ-006 ctrl_enable  in  1  scan enable, bit 0 of the control register from the AXI4-Lite register slave.
REQ-007 ctrl_brightness  in  8  global brightness from the AXI4-Lite register slave, 0 = dark, 255 = max.
REQ-008 fb_addr  out  log2(PLANES)+ROW_W+log2(COLS)  framebuffer read address {plane,row,col}.
REQ-009 fb_data  in  6  {r1,g1,b1,r0,g0,b0} plane bits, valid exactly 1 cycle after fb_addr.
REQ-010 hub_clk, hub_lat, hub_oe_n  out  1 each  panel shift clock, latch, output enable (active-low).
REQ-011 hub_addr  out  ROW_W  panel row select; hub_rgb  out  6  panel colour data.
REQ-012 frame_done  out  1  one-cycle pulse at end of every full frame; busy  out  1  high whenever state != IDLE.

Function
REQ-013 FSM states: IDLE, SHIFT, LATCH, DISPLAY, NEXT; IDLE -> SHIFT on the first edge with ctrl_enable=1, row=0, plane=0.
REQ-014 SHIFT lasts 2*COLS+1 cycles: cycle 0 = prefetch (fb_addr col 0); pixel n then takes 2 cycles: hub_clk=0 with hub_rgb=fb_data, followed by hub_clk=1 with hub_rgb held and fb_addr = col n+1.
REQ-015 After SHIFT: hub_clk=0, hub_rgb holds the last pixel, state -> LATCH.
REQ-016 LATCH lasts 1 cycle: hub_oe_n=1, hub_lat=1, hub_addr <= current row in the same cycle.
REQ-017 DISPLAY window = 256 << plane cycles; hub_oe_n=0 for the first (ctrl_brightness << plane) cycles, then 1; window counter width 8+PLANES-1.
REQ-018 ctrl_brightness is sampled on LATCH exit; changes during DISPLAY take effect on the next plane.
REQ-019 ctrl_brightness=0: hub_oe_n stays 1 for the whole window, and the window length is unchanged.
REQ-020 NEXT lasts 1 cycle: plane++; at plane==PLANES-1, plane=0 and row++; at row wrap (2^ROW_W-1 -> 0), frame_done=1 in that cycle.
REQ-021 From NEXT: -> IDLE if frame_done and ctrl_enable=0, else -> SHIFT.
REQ-022 ctrl_enable deassert mid-frame: the current frame completes before IDLE.
REQ-023 hub_oe_n=1 in every state except DISPLAY; hub_lat=0 outside LATCH.
REQ-024 fb_addr holds its last value outside SHIFT.

Reset
REQ-025 ARESETN=0 sampled at an edge: state=IDLE, row=0, plane=0, counters=0.
REQ-026 Output reset values: hub_clk=0, hub_lat=0, hub_oe_n=1, hub_addr=0, hub_rgb=0, fb_addr=0, frame_done=0, busy=0.
REQ-027 Reset mid-operation (any state) takes priority over all transitions; there is no partial-frame resume.

Structure
REQ-028 Shared package ledcube_pkg holds: state enum scan_state_t, the HUB_RGB_W=6 constant, and the fb_addr width function.
REQ-029 BCM window/OE counter is a sub-module led_bcm_timer (start, plane, brightness -> oe_n, done).
REQ-030 No other sub-modules are used; all outputs are registered.

Verification
REQ-031 Reset held 20 cycles, then released with ctrl_enable=0 -> all outputs at reset values, busy=0 for 100 cycles.
REQ-032 COLS=4, ctrl_enable=1, fb model returns col index -> 4 hub_clk rising edges per row, hub_rgb=0,1,2,3 at each rise, SHIFT = 9 cycles.
REQ-033 ctrl_brightness=128, plane 2 -> hub_oe_n low exactly 512 cycles within a 1024-cycle window.
REQ-034 ctrl_brightness=0 -> hub_oe_n never low and frame period unchanged versus brightness=255.
REQ-035 ROW_W=2, PLANES=2: run 2 frames -> frame_done pulses exactly once per 8 row-plane passes; hub_addr sequence 0,0,1,1,2,2,3,3.
REQ-036 ctrl_enable dropped mid-frame -> frame completes, frame_done pulses, IDLE; ARESETN=0 during DISPLAY -> hub_oe_n=1 on the next edge.

Source files
------------

// File: rtl/ledcube_pkg.sv
// Shared types and constants for the LED panel scan controller and its BCM timer.
package ledcube_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        LATCH,
        DISPLAY,
        NEXT
    } scan_state_t;

    localparam int HUB_RGB_W = 6;

    // Framebuffer address is {plane, row, col}.
    function automatic int fb_addr_width(input int cols, input int row_w, input int planes);
        return $clog2(planes) + row_w + $clog2(cols);
    endfunction

endpackage

// File: rtl/led_bcm_timer.sv
// Binary-code-modulation display window: 256<<plane cycles long, with the output
// enable asserted (low) for the first brightness<<plane cycles.
module led_bcm_timer import ledcube_pkg::*; #(
    parameter int PLANES = 4,
    parameter int PL_W   = 2
) (
    input  logic            ACLK,
    input  logic            ARESETN,
    input  logic            start,
    input  logic [PL_W-1:0] plane,
    input  logic [7:0]      brightness,
    output logic            oe_n,
    output logic            done
);
    localparam int CNT_W = 8 + PLANES - 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lim_q, lim_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             active_q, active_d;
    logic             oe_n_q, oe_n_d;

    always_comb begin
        cnt_d    = cnt_q;
        lim_d    = lim_q;
        last_d   = last_q;
        active_d = active_q;
        oe_n_d   = oe_n_q;
        cnt_inc  = cnt_q + CNT_W'(1);
        if (start) begin
            // Brightness and plane are captured here, so later changes wait for the next window.
            cnt_d    = '0;
            lim_d    = CNT_W'(brightness) << plane;
            last_d   = (CNT_W'(256) << plane) - CNT_W'(1);
            active_d = 1'b1;
            oe_n_d   = (brightness == 8'd0);
        end else if (active_q) begin
            if (cnt_q == last_q) begin
                active_d = 1'b0;
                oe_n_d   = 1'b1;
            end else begin
                cnt_d  = cnt_inc;
                oe_n_d = !(cnt_inc < lim_q);
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            cnt_q    <= '0;
            lim_q    <= '0;
            last_q   <= '0;
            active_q <= 1'b0;
            oe_n_q   <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            lim_q    <= lim_d;
            last_q   <= last_d;
            active_q <= active_d;
            oe_n_q   <= oe_n_d;
        end
    end

    assign oe_n = oe_n_q;
    assign done = active_q && (cnt_q == last_q);

endmodule

// File: rtl/led_scan_ctrl.sv
// HUB75-style LED panel scanner: shifts one row of a bit plane, latches it, shows it
// for a BCM-weighted window, then advances plane/row until the frame wraps.
module led_scan_ctrl import ledcube_pkg::*; #(
    parameter int COLS   = 64,
    parameter int ROW_W  = 5,
    parameter int PLANES = 4
) (
    input  logic                                          ACLK,
    input  logic                                          ARESETN,
    input  logic                                          ctrl_enable,
    input  logic [7:0]                                    ctrl_brightness,
    output logic [fb_addr_width(COLS, ROW_W, PLANES)-1:0] fb_addr,
    input  logic [HUB_RGB_W-1:0]                          fb_data,
    output logic                                          hub_clk,
    output logic                                          hub_lat,
    output logic                                          hub_oe_n,
    output logic [ROW_W-1:0]                              hub_addr,
    output logic [HUB_RGB_W-1:0]                          hub_rgb,
    output logic                                          frame_done,
    output logic                                          busy
);
    localparam int FB_W  = fb_addr_width(COLS, ROW_W, PLANES);
    localparam int COL_W = $clog2(COLS);
    localparam int PL_W  = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int SC_W  = COL_W + 2;

    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(2 * COLS);
    localparam logic [PL_W-1:0]  PL_LAST  = PL_W'(PLANES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = {ROW_W{1'b1}};

    scan_state_t          state_q, state_d;
    logic [ROW_W-1:0]     row_q, row_d;
    logic [PL_W-1:0]      plane_q, plane_d;
    logic [SC_W-1:0]      sc_q, sc_d;
    logic [FB_W-1:0]      fb_addr_q, fb_addr_d;
    logic                 hub_clk_q, hub_clk_d;
    logic                 hub_lat_q, hub_lat_d;
    logic [ROW_W-1:0]     hub_addr_q, hub_addr_d;
    logic [HUB_RGB_W-1:0] hub_rgb_q, hub_rgb_d;
    logic                 frame_done_q, frame_done_d;
    logic                 busy_q, busy_d;
    logic [COL_W-1:0]     col_next;
    logic                 last_pass;
    logic                 bcm_start;
    logic                 bcm_done;
    logic                 bcm_oe_n;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        plane_d      = plane_q;
        sc_d         = sc_q;
        fb_addr_d    = fb_addr_q;
        hub_clk_d    = hub_clk_q;
        hub_lat_d    = 1'b0;
        hub_addr_d   = hub_addr_q;
        hub_rgb_d    = hub_rgb_q;
        frame_done_d = 1'b0;
        bcm_start    = 1'b0;
        col_next     = sc_q[COL_W:1] + COL_W'(1);
        last_pass    = (plane_q == PL_LAST) && (row_q == ROW_LAST);
        case (state_q)
            IDLE: begin
                if (ctrl_enable) begin
                    state_d   = SHIFT;
                    row_d     = '0;
                    plane_d   = '0;
                    sc_d      = '0;
                    fb_addr_d = '0;
                    hub_clk_d = 1'b0;
                end
            end
            SHIFT: begin
                if (sc_q == SC_LAST) begin
                    state_d    = LATCH;
                    hub_clk_d  = 1'b0;
                    hub_lat_d  = 1'b1;
                    hub_addr_d = row_q;
                end else begin
                    sc_d = sc_q + SC_W'(1);
                    // Odd count ends a low phase: raise the clock with the fetched pixel
                    // and request the following column.
                    if (sc_q[0]) begin
                        hub_clk_d = 1'b1;
                        hub_rgb_d = fb_data;
                        fb_addr_d = FB_W'({plane_q, row_q, col_next});
                    end else begin
                        hub_clk_d = 1'b0;
                    end
                end
            end
            LATCH: begin
                state_d   = DISPLAY;
                bcm_start = 1'b1;
            end
            DISPLAY: begin
                if (bcm_done) begin
                    state_d      = NEXT;
                    frame_done_d = last_pass;
                end
            end
            NEXT: begin
                if (plane_q == PL_LAST) begin
                    plane_d = '0;
                    row_d   = row_q + ROW_W'(1);
                end else begin
                    plane_d = plane_q + PL_W'(1);
                end
                if (frame_done_q && !ctrl_enable) begin
                    state_d = IDLE;
                end else begin
                    state_d   = SHIFT;
                    sc_d      = '0;
                    hub_clk_d = 1'b0;
                    fb_addr_d = FB_W'({plane_d, row_d, {COL_W{1'b0}}});
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q      <= IDLE;
            row_q        <= '0;
            plane_q      <= '0;
            sc_q         <= '0;
            fb_addr_q    <= '0;
            hub_clk_q    <= 1'b0;
            hub_lat_q    <= 1'b0;
            hub_addr_q   <= '0;
            hub_rgb_q    <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            plane_q      <= plane_d;
            sc_q         <= sc_d;
            fb_addr_q    <= fb_addr_d;
            hub_clk_q    <= hub_clk_d;
            hub_lat_q    <= hub_lat_d;
            hub_addr_q   <= hub_addr_d;
            hub_rgb_q    <= hub_rgb_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    led_bcm_timer #(
        .PLANES (PLANES),
        .PL_W   (PL_W)
    ) u_bcm (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .start      (bcm_start),
        .plane      (plane_q),
        .brightness (ctrl_brightness),
        .oe_n       (bcm_oe_n),
        .done       (bcm_done)
    );

    assign fb_addr    = fb_addr_q;
    assign hub_clk    = hub_clk_q;
    assign hub_lat    = hub_lat_q;
    assign hub_oe_n   = bcm_oe_n;
    assign hub_addr   = hub_addr_q;
    assign hub_rgb    = hub_rgb_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Self-checking bench for led_scan_ctrl on a small panel (4 cols, 4 rows, 3 planes).
module tb_led_scan_ctrl;
    localparam int COLS   = 4;
    localparam int ROW_W  = 2;
    localparam int ROWS   = 4;
    localparam int PLANES = 3;
    localparam int FB_W   = 6;
    localparam int PASS_OVH = 2 * COLS + 3;
    localparam int FRAME  = ROWS * (PLANES * PASS_OVH + 256 * ((1 << PLANES) - 1));
    localparam logic [18:0] RST_VEC = {6'h00, 1'b0, 1'b0, 1'b1, 2'b00, 6'h00, 1'b0, 1'b0};

    logic             ACLK = 1'b0;
    logic             ARESETN = 1'b0;
    logic             ctrl_enable = 1'b0;
    logic [7:0]       ctrl_brightness = 8'd0;
    logic [FB_W-1:0]  fb_addr;
    logic [5:0]       fb_data;
    logic             hub_clk, hub_lat, hub_oe_n, frame_done, busy;
    logic [ROW_W-1:0] hub_addr;
    logic [5:0]       hub_rgb;
    logic [5:0]       fb_mem [64];

    int errors = 0;
    int checks = 0;

    led_scan_ctrl #(.COLS(COLS), .ROW_W(ROW_W), .PLANES(PLANES)) dut (
        .ACLK            (ACLK),
        .ARESETN         (ARESETN),
        .ctrl_enable     (ctrl_enable),
        .ctrl_brightness (ctrl_brightness),
        .fb_addr         (fb_addr),
        .fb_data         (fb_data),
        .hub_clk         (hub_clk),
        .hub_lat         (hub_lat),
        .hub_oe_n        (hub_oe_n),
        .hub_addr        (hub_addr),
        .hub_rgb         (hub_rgb),
        .frame_done      (frame_done),
        .busy            (busy)
    );

    always #5 ACLK = ~ACLK;

    // Framebuffer with one-cycle registered read
    always @(posedge ACLK) fb_data <= fb_mem[fb_addr];

    function automatic logic [18:0] obs();
        return {fb_addr, hub_clk, hub_lat, hub_oe_n, hub_addr, hub_rgb, frame_done, busy};
    endfunction

    function automatic logic [5:0] faddr(input int p, input int r, input int c);
        return 6'(p * ROWS * COLS + r * COLS + c);
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset(input int n);
        ARESETN = 1'b0;
        repeat (n) tick();
        ARESETN = 1'b1;
    endtask

    task automatic test_reset();
        ctrl_enable = 1'b1;
        ARESETN = 1'b0;
        repeat (20) tick();
        checks++;
        if (obs() !== RST_VEC) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", obs(), RST_VEC);
        end
        ctrl_enable = 1'b0;
        ARESETN = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if (obs() !== RST_VEC) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: got %h expected %h", i, obs(), RST_VEC);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_shift();
        int rises = 0;
        int shift_len = -1;
        logic prev_clk = 1'b0;
        logic [5:0] seen [$];
        bit started = 0;
        for (int i = 0; i < 64; i++) fb_mem[i] = 6'(i % COLS);
        do_reset(3);
        ctrl_brightness = 8'd255;
        ctrl_enable = 1'b1;
        for (int w = 0; w < 4 && !started; w++) begin
            tick();
            if (busy) started = 1;
        end
        checks++;
        if (!started) begin
            errors++;
            $display("FAIL shift_start: busy never rose (got 0 expected 1)");
            return;
        end
        checks++;
        if (fb_addr !== 6'd0) begin
            errors++;
            $display("FAIL shift_prefetch_addr: got %0d expected 0", fb_addr);
        end
        for (int k = 0; k < 16 && shift_len < 0; k++) begin
            if (k > 0) tick();
            if (hub_clk && !prev_clk) begin
                rises++;
                seen.push_back(hub_rgb);
            end
            prev_clk = hub_clk;
            if (hub_lat) begin
                shift_len = k;
                checks++;
                if (hub_addr !== 2'd0 || hub_clk !== 1'b0 || hub_rgb !== 6'd3) begin
                    errors++;
                    $display("FAIL shift_latch: got addr=%0d clk=%b rgb=%0d expected 0 0 3", hub_addr, hub_clk, hub_rgb);
                end
            end
        end
        checks++;
        if (rises != COLS) begin
            errors++;
            $display("FAIL shift_rises: got %0d expected %0d", rises, COLS);
        end
        checks++;
        if (shift_len != 2 * COLS + 1) begin
            errors++;
            $display("FAIL shift_length: got %0d expected %0d", shift_len, 2 * COLS + 1);
        end
        for (int n = 0; n < seen.size(); n++) begin
            checks++;
            if (seen[n] !== 6'(n)) begin
                errors++;
                $display("FAIL shift_rgb pixel %0d: got %0d expected %0d", n, seen[n], n);
            end
        end
        $display("test_shift done: rises=%0d len=%0d", rises, shift_len);
    endtask

    // Cycle-by-cycle comparison against a timeline built from the pass schedule.
    task automatic test_frames();
        logic [5:0] m_fb = 6'd0, m_rgb = 6'd0;
        logic [1:0] m_addr = 2'd0;
        logic e_clk, e_lat, e_oe, e_done;
        logic [18:0] exp_v;
        for (int i = 0; i < 64; i++) fb_mem[i] = 6'($urandom);
        do_reset(3);
        ctrl_enable = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int p = 0; p < PLANES; p++) begin
                    int b, w, lim, sel;
                    bit last;
                    sel = int'($urandom_range(0, 3));
                    b = (sel == 0) ? 0 : (sel == 1) ? 255 : int'($urandom_range(1, 254));
                    w = 256 << p;
                    lim = b << p;
                    last = (r == ROWS - 1) && (p == PLANES - 1);
                    ctrl_brightness = 8'(b);
                    for (int c = 0; c < PASS_OVH + w; c++) begin
                        tick();
                        e_clk = 1'b0; e_lat = 1'b0; e_oe = 1'b1; e_done = 1'b0;
                        if (c <= 2 * COLS) begin
                            m_fb = faddr(p, r, (c / 2) % COLS);
                            if (c >= 2) m_rgb = fb_mem[faddr(p, r, c / 2 - 1)];
                            e_clk = (c >= 2) && (c % 2 == 0);
                        end else if (c == 2 * COLS + 1) begin
                            e_lat = 1'b1;
                            m_addr = 2'(r);
                        end else if (c < 2 * COLS + 2 + w) begin
                            e_oe = ((c - (2 * COLS + 2)) < lim) ? 1'b0 : 1'b1;
                        end else begin
                            e_done = last;
                        end
                        exp_v = {m_fb, e_clk, e_lat, e_oe, m_addr, m_rgb, e_done, 1'b1};
                        checks++;
                        if (obs() !== exp_v) begin
                            errors++;
                            $display("FAIL frames f%0d r%0d p%0d c%0d: got %h expected %h", f, r, p, c, obs(), exp_v);
                        end
                        if (c == 2 * COLS + 2 + w / 2) ctrl_brightness = 8'($urandom);
                        if (f == 1 && r == 1 && p == 1 && c == 5) ctrl_enable = 1'b0;
                    end
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_v = {m_fb, 1'b0, 1'b0, 1'b1, m_addr, m_rgb, 1'b0, 1'b0};
            checks++;
            if (obs() !== exp_v) begin
                errors++;
                $display("FAIL frames_idle cycle %0d: got %h expected %h", i, obs(), exp_v);
            end
        end
        $display("test_frames done");
    endtask

    task automatic test_bcm();
        int nlat = 0;
        int gap = 0;
        int oe_low = 0;
        bool_loop: for (int i = 0; i < 4000; i++) begin
            if (i == 0) begin
                do_reset(3);
                ctrl_brightness = 8'd128;
                ctrl_enable = 1'b1;
            end
            tick();
            if (nlat == 3) begin
                gap++;
                if (!hub_oe_n) oe_low++;
                if (gap == 1 || gap == 512 || gap == 513) begin
                    checks++;
                    if (hub_oe_n !== (gap == 513)) begin
                        errors++;
                        $display("FAIL bcm_oe_edge at %0d: got %b expected %b", gap, hub_oe_n, gap == 513);
                    end
                end
            end
            if (hub_lat) begin
                nlat++;
                if (nlat == 4) break;
            end
        end
        checks++;
        if (nlat != 4) begin
            errors++;
            $display("FAIL bcm_timeout: got %0d latches expected 4", nlat);
        end
        checks++;
        if (oe_low != 512) begin
            errors++;
            $display("FAIL bcm_oe_low: got %0d expected 512", oe_low);
        end
        checks++;
        if (gap - PASS_OVH != 1024) begin
            errors++;
            $display("FAIL bcm_window: got %0d expected 1024", gap - PASS_OVH);
        end
        $display("test_bcm done: oe_low=%0d window=%0d", oe_low, gap - PASS_OVH);
    endtask

    task automatic test_dark_vs_max();
        int period [2];
        for (int t = 0; t < 2; t++) begin
            int nlat = 0, oe_low = 0, ndone = 0;
            bit started = 0;
            period[t] = -1;
            do_reset(3);
            ctrl_brightness = (t == 0) ? 8'd0 : 8'd255;
            ctrl_enable = 1'b1;
            for (int w = 0; w < 4 && !started; w++) begin
                tick();
                if (busy) started = 1;
            end
            ctrl_enable = 1'b0;
            for (int c = 0; c < FRAME + 200 && started; c++) begin
                if (c > 0) tick();
                if (!hub_oe_n) oe_low++;
                if (hub_lat) begin
                    checks++;
                    if (hub_addr !== 2'(nlat / PLANES)) begin
                        errors++;
                        $display("FAIL dark_hub_addr latch %0d: got %0d expected %0d", nlat, hub_addr, nlat / PLANES);
                    end
                    nlat++;
                end
                if (frame_done) begin
                    ndone++;
                    if (period[t] < 0) period[t] = c;
                end
            end
            checks++;
            if (period[t] != FRAME - 1) begin
                errors++;
                $display("FAIL frame_period b=%0d: got %0d expected %0d", ctrl_brightness, period[t], FRAME - 1);
            end
            checks++;
            if (ndone != 1 || nlat != ROWS * PLANES) begin
                errors++;
                $display("FAIL frame_counts b=%0d: got done=%0d lat=%0d expected 1 %0d", ctrl_brightness, ndone, nlat, ROWS * PLANES);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL frame_idle b=%0d: got busy=%b expected 0", ctrl_brightness, busy);
            end
            if (t == 0) begin
                checks++;
                if (oe_low != 0) begin
                    errors++;
                    $display("FAIL dark_oe: got %0d low cycles expected 0", oe_low);
                end
            end
        end
        checks++;
        if (period[0] != period[1]) begin
            errors++;
            $display("FAIL dark_vs_max_period: got %0d expected %0d", period[0], period[1]);
        end
        $display("test_dark_vs_max done: periods %0d %0d", period[0], period[1]);
    endtask

    task automatic test_reset_mid();
        bit hit = 0;
        do_reset(3);
        ctrl_brightness = 8'd255;
        ctrl_enable = 1'b1;
        for (int i = 0; i < 100 && !hit; i++) begin
            tick();
            if (hub_oe_n === 1'b0) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL reset_mid_display: got no DISPLAY expected oe_n low");
            return;
        end
        ARESETN = 1'b0;
        tick();
        checks++;
        if (obs() !== RST_VEC) begin
            errors++;
            $display("FAIL reset_mid: got %h expected %h", obs(), RST_VEC);
        end
        ARESETN = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1 || fb_addr !== 6'd0 || hub_clk !== 1'b0) begin
            errors++;
            $display("FAIL reset_restart: got busy=%b fb=%0d clk=%b expected 1 0 0", busy, fb_addr, hub_clk);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        for (int i = 0; i < 64; i++) fb_mem[i] = 6'd0;
        test_reset();
        test_shift();
        test_bcm();
        test_reset_mid();
        test_frames();
        test_dark_vs_max();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
